// File: rtl/reg_file_mp.sv
// Multi-read-port register file with a byte-enabled write port, write-first
// bypass on reads and a per-register busy scoreboard (reserve/write/flush).
module reg_file_mp #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int NRD  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     i_rd_addr,
  output logic [NRD*XLEN-1:0]   o_rd_dat,
  output logic [NRD-1:0]        o_rd_busy,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [XLEN-1:0]       i_wr_dat,
  input  logic [XLEN/8-1:0]     i_wr_be,
  input  logic                  i_rsv_en,
  input  logic [AW-1:0]         i_rsv_addr,
  input  logic                  i_flush,
  output logic [NREG-1:0]       o_busy_vec
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            wr_hit;
  logic [XLEN-1:0] wr_val;
  logic [AW-1:0]   rd_a   [NRD];
  logic [XLEN-1:0] rd_val [NRD];
  logic            rd_bsy [NRD];

  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0]   old,
                                            input logic [XLEN-1:0]   dat,
                                            input logic [XLEN/8-1:0] be);
    merge = old;
    for (int unsigned b = 0; b < XLEN/8; b++)
      if (be[b]) merge[8*b +: 8] = dat[8*b +: 8];
  endfunction

  assign wr_hit = i_wr_en && (i_wr_addr != '0);
  assign wr_val = merge(regs[i_wr_addr], i_wr_dat, i_wr_be);

  // Write clears first, then reserve sets, so reserve outranks a same-cycle write.
  always_comb begin
    busy_nxt = busy;
    if (i_flush) begin
      busy_nxt = '0;
    end else begin
      if (wr_hit) busy_nxt[i_wr_addr] = 1'b0;
      if (i_rsv_en && (i_rsv_addr != '0)) busy_nxt[i_rsv_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    for (int unsigned k = 0; k < NRD; k++) begin
      rd_a[k]   = i_rd_addr[k*AW +: AW];
      rd_val[k] = (wr_hit && (i_wr_addr == rd_a[k])) ? wr_val : regs[rd_a[k]];
      rd_bsy[k] = busy_nxt[rd_a[k]];
    end
  end

  // Entry 0 is only ever reset, so it stays a constant zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) regs[r] <= '0;
      busy      <= '0;
      o_rd_dat  <= '0;
      o_rd_busy <= '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++)
        if (wr_hit && (i_wr_addr == AW'(r))) regs[r] <= wr_val;
      busy <= busy_nxt;
      for (int unsigned k = 0; k < NRD; k++) begin
        o_rd_dat[k*XLEN +: XLEN] <= rd_val[k];
        o_rd_busy[k]             <= rd_bsy[k];
      end
    end
  end

  assign o_busy_vec = busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus random traffic
// compared against an array-based reference model.
module tb_reg_file_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_dat;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_dat;
  logic [XLEN/8-1:0]   wr_be;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                flush;
  logic [NREG-1:0]     busy_vec;

  int tests = 0;
  int fails = 0;

  logic [31:0] mreg  [NREG];
  logic [31:0] mbusy;

  always #5 clk = ~clk;

  reg_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_rd_addr (rd_addr),
    .o_rd_dat  (rd_dat),
    .o_rd_busy (rd_busy),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_dat  (wr_dat),
    .i_wr_be   (wr_be),
    .i_rsv_en  (rsv_en),
    .i_rsv_addr(rsv_addr),
    .i_flush   (flush),
    .o_busy_vec(busy_vec)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = '0; wr_dat = '0; wr_be = '0;
    rsv_en = 0; rsv_addr = '0; flush = 0; rd_addr = '0;
  endtask

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) mreg[r] = '0;
    mbusy = '0;
  endtask

  // One clock: predict from the spec rules, advance, then compare everything.
  task automatic tick(input string tag);
    logic [31:0] nreg [NREG];
    logic [31:0] nbusy;
    logic [31:0] exp_dat [NRD];
    logic        exp_bsy [NRD];
    int          a;
    for (int r = 0; r < NREG; r++) nreg[r] = mreg[r];
    nbusy = mbusy;
    if (!rst) begin
      if (wr_en && wr_addr != 0)
        for (int b = 0; b < 4; b++)
          if (wr_be[b]) nreg[wr_addr][8*b +: 8] = wr_dat[8*b +: 8];
      for (int r = 1; r < NREG; r++) begin
        if (flush)                      nbusy[r] = 1'b0;
        else if (rsv_en && rsv_addr == r) nbusy[r] = 1'b1;
        else if (wr_en && wr_addr == r)   nbusy[r] = 1'b0;
      end
    end
    for (int k = 0; k < NRD; k++) begin
      a = int'(rd_addr[k*AW +: AW]);
      exp_dat[k] = rst ? 32'h0 : nreg[a];
      exp_bsy[k] = rst ? 1'b0 : nbusy[a];
    end
    @(posedge clk); #1;
    for (int r = 0; r < NREG; r++) mreg[r] = nreg[r];
    mbusy = nbusy;
    for (int k = 0; k < NRD; k++) begin
      check($sformatf("%s.dat%0d", tag, k), rd_dat[k*XLEN +: XLEN], exp_dat[k]);
      check($sformatf("%s.bsy%0d", tag, k), {31'b0, rd_busy[k]}, {31'b0, exp_bsy[k]});
    end
    check($sformatf("%s.bvec", tag), busy_vec, mbusy);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("reset.dat", rd_dat[31:0], 32'h0);
    check("reset.bvec", busy_vec, 32'h0);
    rst = 1'b0;

    // basic write then read
    wr_en = 1; wr_addr = 5; wr_dat = 32'hDEADBEEF; wr_be = 4'hF;
    tick("wr5");
    idle(); rd_addr = {5'd0, 5'd5};
    tick("rd5");
    check("basic.dat", rd_dat[31:0], 32'hDEADBEEF);
    check("basic.bsy", {31'b0, rd_busy[0]}, 32'h0);

    // byte-enable write with same-cycle bypass on port 1
    wr_en = 1; wr_addr = 5; wr_dat = 32'h11223344; wr_be = 4'h3; rd_addr = {5'd5, 5'd0};
    tick("byp5");
    check("bypass.dat", rd_dat[63:32], 32'hDEAD3344);

    // register 0 protection
    idle(); wr_en = 1; wr_addr = 0; wr_dat = 32'hFFFFFFFF; wr_be = 4'hF;
    rsv_en = 1; rsv_addr = 0;
    tick("x0w");
    idle();
    tick("x0r");
    check("x0.dat0", rd_dat[31:0], 32'h0);
    check("x0.dat1", rd_dat[63:32], 32'h0);
    check("x0.bvec0", {31'b0, busy_vec[0]}, 32'h0);

    // scoreboard sequence on x7
    idle(); rsv_en = 1; rsv_addr = 7; rd_addr = {5'd7, 5'd7};
    tick("sb1");
    check("sb.rsv", {31'b0, busy_vec[7]}, 32'h1);
    wr_en = 1; wr_addr = 7; wr_dat = 32'hA5A5A5A5; wr_be = 4'hF;
    tick("sb2");
    check("sb.rsvwr", {31'b0, busy_vec[7]}, 32'h1);
    check("sb.rsvwr.dat", rd_dat[31:0], 32'hA5A5A5A5);
    rsv_en = 0; wr_dat = 32'h5A5A5A5A;
    tick("sb3");
    check("sb.wr", {31'b0, busy_vec[7]}, 32'h0);

    // flush outranks reserve
    idle(); rsv_en = 1; rsv_addr = 3;
    tick("fl1");
    rsv_addr = 9;
    tick("fl2");
    check("fl.pre", busy_vec, 32'h0000_0208);
    rsv_addr = 4; flush = 1;
    tick("fl3");
    check("fl.post", busy_vec, 32'h0);

    // asynchronous reset with x5 busy and nonzero
    idle(); rsv_en = 1; rsv_addr = 5; rd_addr = {5'd5, 5'd5};
    tick("rs1");
    check("rs.pre", {31'b0, busy_vec[5]}, 32'h1);
    #3 rst = 1'b1;
    #1;
    check("rs.async.dat", rd_dat[31:0], 32'h0);
    check("rs.async.bsy", {30'b0, rd_busy}, 32'h0);
    check("rs.async.bvec", busy_vec, 32'h0);
    model_clear();
    wr_en = 1; wr_addr = 5; wr_dat = 32'hCAFEF00D; wr_be = 4'hF; rsv_en = 1; rsv_addr = 6;
    tick("rs.hold1");
    tick("rs.hold2");
    rst = 1'b0;
    idle(); rd_addr = {5'd6, 5'd5};
    tick("rs.after");
    check("rs.after.dat", rd_dat[31:0], 32'h0);
    check("rs.after.bsy", {31'b0, rd_busy[0]}, 32'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = AW'($urandom);
      wr_dat   = $urandom;
      wr_be    = 4'($urandom);
      rsv_en   = 1'($urandom_range(0, 2) == 0);
      rsv_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
      flush    = ($urandom_range(0, 19) == 0);
      rd_addr  = NRD*AW'($urandom);
      if ($urandom_range(0, 2) == 0) rd_addr[AW-1:0] = wr_addr;
      if ($urandom_range(0, 3) == 0) rd_addr[2*AW-1:AW] = rd_addr[AW-1:0];
      tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: register width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter NREG, default 32: register count, a power of 2 and at least 2; AW = log2(NREG).
REQ-003 The block SHALL have parameter NRD, default 2: read port count, 1..4.
REQ-004 The block SHALL have port clk, input, 1 bit: all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port i_rd_addr, input, NRD*AW bits: read address per port; port k occupies bits [k*AW +: AW].
REQ-007 The block SHALL have port o_rd_dat, output, NRD*XLEN bits: registered read data per port.
REQ-008 The block SHALL have port o_rd_busy, output, NRD bits: registered scoreboard busy flag for each port's address.
REQ-009 The block SHALL have port i_wr_en, input, 1 bit: write strobe.
REQ-010 The block SHALL have port i_wr_addr, input, AW bits: write address.
REQ-011 The block SHALL have port i_wr_dat, input, XLEN bits: write data.
REQ-012 The block SHALL have port i_wr_be, input, XLEN/8 bits: byte enables for the write.
REQ-013 The block SHALL have port i_rsv_en, input, 1 bit: reserve strobe, marking a register as pending a write.
REQ-014 The block SHALL have port i_rsv_addr, input, AW bits: address to reserve.
REQ-015 The block SHALL have port i_flush, input, 1 bit: clears every busy bit.
REQ-016 The block SHALL have port o_busy_vec, output, NREG bits: current scoreboard contents, one bit per register.

Function
REQ-017 Register 0 SHALL always read 0, SHALL never be written, and SHALL never be marked busy; writes and reserves addressed to 0 are ignored.
REQ-018 Registers 1..NREG-1 SHALL be flip-flops (not inferred RAM), each loaded at the clock edge when i_wr_en=1 and i_wr_addr matches.
REQ-019 Each write SHALL update only the bytes whose i_wr_be bit is 1; i_wr_be=0 with i_wr_en=1 leaves the data unchanged but still counts as a write for the scoreboard.
REQ-020 Read latency SHALL be 1 cycle: o_rd_dat port k at edge n+1 equals the register addressed by i_rd_addr port k at edge n.
REQ-021 Reads SHALL be write-first: if a same-cycle write hits the read address, o_rd_dat SHALL return the byte-merged new value, with enabled bytes taken from i_wr_dat and the rest from the old value.
REQ-022 All read ports SHALL be independent; the same address on several ports SHALL return identical data.
REQ-023 Next busy state, per register r != 0, in priority order:
  - if i_flush, then 0;
  - else if i_rsv_en and i_rsv_addr == r, then 1;
  - else if i_wr_en and i_wr_addr == r, then 0;
  - else hold.
REQ-024 Reserve and write to the same register in the same cycle SHALL leave busy=1 and SHALL still commit the write data.
REQ-025 o_rd_busy port k SHALL equal the next-state busy bit (per REQ-023) of the address on that port, registered with the same 1-cycle latency as o_rd_dat.
REQ-026 o_busy_vec SHALL be the registered busy state, with bit 0 constantly 0.
REQ-027 Reserving an already-busy register SHALL keep it busy, with no error and no counting.

Reset
REQ-028 While rst=1, all registers, all busy bits, o_rd_dat, o_rd_busy and o_busy_vec SHALL be 0, asynchronously.
REQ-029 Writes, reserves and flushes presented while rst=1 SHALL be discarded.
REQ-030 Reset asserted mid-operation SHALL also clear pending reservations; the first read after deassertion returns 0 and not-busy for every address.

Verification
REQ-031 Basic write and read: write x5=0xDEADBEEF with be=0xF, then read x5 on port 0 next cycle -> o_rd_dat[0]=0xDEADBEEF, o_rd_busy[0]=0.
REQ-032 Byte-enable write with bypass: x5=0xDEADBEEF, then in the same cycle write 0x11223344 with be=0x3 and read x5 on port 1 -> 0xDEAD3344.
REQ-033 Register 0 protection: write x0=0xFFFFFFFF and reserve x0 -> reads return 0, o_busy_vec[0]=0.
REQ-034 Scoreboard sequence:
  - reserve x7 -> o_busy_vec[7]=1;
  - then reserve x7 together with a write to x7 -> busy stays 1;
  - then write x7 alone -> busy=0.
REQ-035 Flush priority: reserve x3 and x9 over two cycles, then assert i_flush together with i_rsv_en to x4 -> o_busy_vec=0.
REQ-036 Reset: assert rst asynchronously between clock edges with x5 busy and nonzero -> outputs 0 immediately; after release, reading x5 gives 0 and not busy.
